rr_stream_mux: RTL and testbench

- Parametrised successor to the combinational 2:1/4:1 byte muxes in the CPU datapath.
- Selects one of CHANNELS input streams of WIDTH bits onto a single registered output stream with valid/ready handshakes.
- Two modes: fixed select (host-driven sel) or round-robin arbitration with packet locking.
- Sits between peripheral/bus sources and the CPU's shared operand/IO bus.

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rr_stream_mux.sv | 122 ++++++++++++
 tb/tb_rr_stream_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared encodings for the round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester after i_ptr, modulo CHANNELS.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic                o_gnt_valid,
    output logic [SEL_W-1:0]    o_gnt_idx
);

    int w_c;

    // Walk from farthest to nearest so the nearest requester wins last.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_c         = 0;
        for (int i = CHANNELS; i >= 1; i--) begin
            w_c = int'(i_ptr) + i;
            if (w_c >= CHANNELS) begin
                w_c = w_c - CHANNELS;
            end
            if (i_req[w_c]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = SEL_W'(w_c);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream mux with fixed select or round-robin arbitration,
// packet locking and a registered valid/ready output stage.
module rr_stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] dIn,
    input  logic [CHANNELS-1:0]       dInValid,
    input  logic [CHANNELS-1:0]       dInLast,
    output logic [CHANNELS-1:0]       dInReady,
    output logic [WIDTH-1:0]          dOut,
    output logic                      dOutValid,
    output logic                      dOutLast,
    input  logic                      dOutReady,
    output logic [SEL_W-1:0]          grantIdx
);

    state_t           r_state;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] r_lock_idx;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_last;
    logic [SEL_W-1:0] r_gidx;

    logic             w_arb_valid;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_free;
    logic             w_xfer;
    logic             w_in_last;
    logic [WIDTH-1:0] w_in_data;

    rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arb (
        .i_req      (dInValid),
        .i_ptr      (r_rr_ptr),
        .o_gnt_valid(w_arb_valid),
        .o_gnt_idx  (w_arb_idx)
    );

    // mode/sel only matter between packets; a lock pins the grant.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        if (r_state == ST_LOCKED) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = r_lock_idx;
        end else if (mode == MODE_RR) begin
            w_gnt_valid = w_arb_valid;
            w_gnt_idx   = w_arb_idx;
        end else if (int'(sel) < CHANNELS) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = sel;
        end
    end

    assign w_free    = !r_valid || dOutReady;
    assign w_xfer    = w_gnt_valid && w_free && dInValid[w_gnt_idx];
    assign w_in_last = dInLast[w_gnt_idx];
    assign w_in_data = dIn[int'(w_gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        dInReady = '0;
        if (w_gnt_valid) begin
            dInReady[w_gnt_idx] = w_free;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= SEL_W'(CHANNELS - 1);
            r_lock_idx <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_gidx     <= '0;
        end else if (w_xfer) begin
            r_dout  <= w_in_data;
            r_last  <= w_in_last;
            r_gidx  <= w_gnt_idx;
            r_valid <= 1'b1;
            unique case (r_state)
                ST_ARB: begin
                    if (mode == MODE_RR) begin
                        if (w_in_last) begin
                            r_rr_ptr <= w_gnt_idx;
                        end else begin
                            r_lock_idx <= w_gnt_idx;
                            r_state    <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_in_last) begin
                        r_rr_ptr <= r_lock_idx;
                        r_state  <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end else if (w_free) begin
            r_valid <= 1'b0;
        end
    end

    assign dOut      = r_dout;
    assign dOutValid = r_valid;
    assign dOutLast  = r_last;
    assign grantIdx  = r_gidx;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench: a 4-channel instance driven from a vector table and a
// 3-channel instance for non-power-of-two boundaries.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m4 = 0;
    logic [1:0]  s4 = 0;
    logic [31:0] d4 = 0;
    logic [3:0]  v4 = 0;
    logic [3:0]  l4 = 0;
    logic        or4 = 0;
    logic [3:0]  rdy4;
    logic [7:0]  q4;
    logic        qv4;
    logic        ql4;
    logic [1:0]  g4;

    logic        m3 = 0;
    logic [1:0]  s3 = 0;
    logic [23:0] d3 = 0;
    logic [2:0]  v3 = 0;
    logic [2:0]  l3 = 0;
    logic        or3 = 0;
    logic [2:0]  rdy3;
    logic [7:0]  q3;
    logic        qv3;
    logic        ql3;
    logic [1:0]  g3;

    rr_stream_mux #(.WIDTH(8), .CHANNELS(4)) u4 (
        .clk(clk), .rst(rst), .mode(m4), .sel(s4),
        .dIn(d4), .dInValid(v4), .dInLast(l4), .dInReady(rdy4),
        .dOut(q4), .dOutValid(qv4), .dOutLast(ql4),
        .dOutReady(or4), .grantIdx(g4)
    );

    rr_stream_mux #(.WIDTH(8), .CHANNELS(3)) u3 (
        .clk(clk), .rst(rst), .mode(m3), .sel(s3),
        .dIn(d3), .dInValid(v3), .dInLast(l3), .dInReady(rdy3),
        .dOut(q3), .dOutValid(qv3), .dOutLast(ql3),
        .dOutReady(or3), .grantIdx(g3)
    );

    typedef struct {
        logic        m;
        logic [1:0]  s;
        logic [31:0] d;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic [7:0]  e_q;
        logic        e_v;
        logic        e_l;
        logic [1:0]  e_g;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(
        input logic m, input logic [1:0] s, input logic [31:0] d,
        input logic [3:0] v, input logic [3:0] l, input logic ordy,
        input logic [3:0] er, input logic [7:0] eq, input logic ev,
        input logic el, input logic [1:0] eg);
        vec_t t;
        t.m = m; t.s = s; t.d = d; t.v = v; t.l = l; t.ordy = ordy;
        t.e_rdy = er; t.e_q = eq; t.e_v = ev; t.e_l = el; t.e_g = eg;
        return t;
    endfunction

    localparam logic [31:0] D  = 32'hC3A5_1100;
    localparam logic [31:0] D2 = 32'hC3A5_2200;
    localparam logic [31:0] D3 = 32'hC3A5_3300;

    vec_t vt[18];

    initial begin
        vt[0]  = mk(0, 2, D,  4'hF, 4'h0, 1, 4'b0100, 8'hA5, 1, 0, 2);
        vt[1]  = mk(0, 3, D,  4'hF, 4'h0, 1, 4'b1000, 8'hC3, 1, 0, 3);
        vt[2]  = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b0001, 8'h00, 1, 1, 0);
        vt[3]  = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b0010, 8'h11, 1, 1, 1);
        vt[4]  = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b0100, 8'hA5, 1, 1, 2);
        vt[5]  = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b1000, 8'hC3, 1, 1, 3);
        vt[6]  = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b0001, 8'h00, 1, 1, 0);
        vt[7]  = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b0010, 8'h11, 1, 1, 1);
        vt[8]  = mk(1, 0, D,  4'h1, 4'hF, 1, 4'b0001, 8'h00, 1, 1, 0);
        vt[9]  = mk(1, 0, D,  4'h7, 4'h0, 1, 4'b0010, 8'h11, 1, 0, 1);
        vt[10] = mk(0, 0, D2, 4'h7, 4'h0, 1, 4'b0010, 8'h22, 1, 0, 1);
        vt[11] = mk(1, 0, D3, 4'h7, 4'h2, 1, 4'b0010, 8'h33, 1, 1, 1);
        vt[12] = mk(1, 0, D,  4'h7, 4'h5, 1, 4'b0100, 8'hA5, 1, 1, 2);
        vt[13] = mk(1, 0, D,  4'hF, 4'hF, 0, 4'b0000, 8'hA5, 1, 1, 2);
        vt[14] = mk(1, 0, D,  4'hF, 4'hF, 0, 4'b0000, 8'hA5, 1, 1, 2);
        vt[15] = mk(1, 0, D,  4'hF, 4'hF, 0, 4'b0000, 8'hA5, 1, 1, 2);
        vt[16] = mk(1, 0, D,  4'hF, 4'hF, 1, 4'b1000, 8'hC3, 1, 1, 3);
        vt[17] = mk(1, 0, D,  4'h0, 4'hF, 1, 4'b0000, 8'hC3, 0, 1, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("rst4_valid", 32'(qv4), 0);
        chk("rst4_dout", 32'(q4), 0);
        chk("rst4_last", 32'(ql4), 0);
        chk("rst4_gidx", 32'(g4), 0);
        chk("rst3_valid", 32'(qv3), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            m4 = vt[i].m; s4 = vt[i].s; d4 = vt[i].d;
            v4 = vt[i].v; l4 = vt[i].l; or4 = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(rdy4), 32'(vt[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dout", i), 32'(q4), 32'(vt[i].e_q));
            chk($sformatf("v%0d_valid", i), 32'(qv4), 32'(vt[i].e_v));
            chk($sformatf("v%0d_last", i), 32'(ql4), 32'(vt[i].e_l));
            chk($sformatf("v%0d_gidx", i), 32'(g4), 32'(vt[i].e_g));
        end

        // CHANNELS=3: out-of-range fixed select grants nothing
        @(negedge clk);
        m3 = 0; s3 = 3; d3 = 24'h332211; v3 = 3'b111; l3 = 3'b111; or3 = 1;
        #1 chk("c3_sel3_ready", 32'(rdy3), 0);
        @(posedge clk);
        #1 chk("c3_sel3_valid", 32'(qv3), 0);

        // only ch2 valid: granted twice back to back through the wrap
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            m3 = 1; v3 = 3'b100;
            #1 chk($sformatf("c3_wrap%0d_ready", k), 32'(rdy3), 32'b100);
            @(posedge clk);
            #1;
            chk($sformatf("c3_wrap%0d_valid", k), 32'(qv3), 1);
            chk($sformatf("c3_wrap%0d_gidx", k), 32'(g3), 2);
            chk($sformatf("c3_wrap%0d_dout", k), 32'(q3), 32'h33);
        end
        @(negedge clk);
        v3 = 3'b111;
        #1 chk("c3_next_ready", 32'(rdy3), 32'b001);
        @(posedge clk);
        #1;
        chk("c3_next_gidx", 32'(g3), 0);
        chk("c3_next_dout", 32'(q3), 32'h11);

        // async reset while locked on ch1
        @(negedge clk);
        m4 = 1; d4 = D; v4 = 4'b0010; l4 = 4'h0; or4 = 1;
        @(posedge clk);
        #1;
        chk("lk_gidx", 32'(g4), 1);
        chk("lk_valid", 32'(qv4), 1);
        @(negedge clk);
        v4 = 4'hF;
        #1 chk("lk_ready", 32'(rdy4), 32'b0010);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(qv4), 0);
        chk("arst_gidx", 32'(g4), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        v4 = 4'hF; l4 = 4'hF;
        #1 chk("post_rst_ready", 32'(rdy4), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_gidx", 32'(g4), 0);
        chk("post_rst_valid", 32'(qv4), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
